// File: rtl/l0_skew_feeder.sv
// rtl/l0_skew_feeder.sv - West-edge MAC-array feeder: buffered row vectors issued per lane with diagonal skew.
// Optional diagonal skew is enabled by defining FEEDER_SKEW_EN; otherwise all lanes issue together.
module l0_skew_feeder #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr,
    input  logic [row*bw-1:0]         i_in,
    output logic                      o_full,
    input  logic                      i_start_load,
    input  logic                      i_start_exec,
    input  logic [$clog2(depth):0]    i_len,
    output logic [row*bw-1:0]         o_out,
    output logic [row*2-1:0]          o_inst_w,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);
    localparam int PW = $clog2(depth) + 1;
    localparam int AW = PW - 1;
    localparam int TW = $clog2(depth + row) + 2;
`ifdef FEEDER_SKEW_EN
    localparam int NRP = row;
`else
    localparam int NRP = 1;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [row*bw-1:0]   r_mem [depth];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp [NRP];
    logic [PW-1:0]       r_len;
    logic [1:0]          r_code;
    logic [TW-1:0]       r_tick;
    logic [row*bw-1:0]   r_out;
    logic [row*2-1:0]    r_inst;
    logic                r_full;
    logic                r_done;
    logic                r_err;

    logic                w_push;
    logic                w_accept;
    logic                w_reject;
    logic                w_active;
    logic [TW-1:0]       w_t;
    logic [PW-1:0]       w_len_eff;
    logic [TW-1:0]       w_len_t;
    logic [1:0]          w_code;
    logic [PW-1:0]       w_occ0;
    logic [PW-1:0]       w_wp_nx;
    logic [PW-1:0]       w_rpl_nx;
    logic [TW-1:0]       w_done_t;
    logic [row-1:0]      w_issue;
    logic [AW-1:0]       w_rd_addr [row];

    assign w_push  = i_wr && !r_full;
    assign w_occ0  = r_wp - r_rp[0];
    assign w_len_t = TW'(w_len_eff);

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        w_t        = r_tick;
        w_len_eff  = r_len;
        w_code     = r_code;
        case (r_state)
            ST_IDLE: begin
                w_t = '0;
                if (i_start_load || i_start_exec) begin
                    if ((i_start_load ^ i_start_exec) && (i_len != '0) &&
                        (i_len <= PW'(depth)) && (w_occ0 >= i_len)) begin
                        w_accept   = 1'b1;
                        w_state_nx = ST_RUN;
                        w_len_eff  = i_len;
                        w_code     = i_start_exec ? 2'b10 : 2'b01;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
`ifdef FEEDER_SKEW_EN
            ST_RUN: begin
                if (r_tick == TW'(r_len)) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_tick == TW'(r_len) + TW'(row)) w_state_nx = ST_IDLE;
            end
`else
            ST_RUN: begin
                if (r_tick == TW'(r_len) + TW'(1)) w_state_nx = ST_IDLE;
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
        w_active = w_accept || (r_state != ST_IDLE);
    end

    // w_t indexes the output cycle being loaded at this edge: 0 on the accept edge.
    always_comb begin
        w_issue = '0;
        for (int r = 0; r < row; r++) begin
`ifdef FEEDER_SKEW_EN
            w_issue[r]   = w_active && (w_t >= TW'(r)) && (w_t < TW'(r) + w_len_t);
            w_rd_addr[r] = r_rp[r][AW-1:0];
`else
            w_issue[r]   = w_active && (w_t < w_len_t);
            w_rd_addr[r] = r_rp[0][AW-1:0];
`endif
        end
    end

`ifdef FEEDER_SKEW_EN
    assign w_done_t = TW'(r_len) + TW'(row - 1);
`else
    assign w_done_t = TW'(r_len);
`endif

    assign w_wp_nx  = r_wp + PW'(w_push);
    assign w_rpl_nx = r_rp[NRP-1] + PW'(w_issue[NRP-1]);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_wp    <= '0;
            for (int i = 0; i < NRP; i++) r_rp[i] <= '0;
            r_len   <= '0;
            r_code  <= 2'b00;
            r_tick  <= '0;
            r_out   <= '0;
            r_inst  <= '0;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_wp    <= w_wp_nx;
            for (int i = 0; i < NRP; i++) begin
                if (w_issue[i]) r_rp[i] <= r_rp[i] + 1'b1;
            end
            r_len   <= w_len_eff;
            r_code  <= w_code;
            r_tick  <= w_active ? w_t + 1'b1 : '0;
            for (int r = 0; r < row; r++) begin
                if (w_issue[r]) begin
                    r_out[r*bw +: bw] <= r_mem[w_rd_addr[r]][r*bw +: bw];
                    r_inst[r*2 +: 2]  <= w_code;
                end else begin
                    r_out[r*bw +: bw] <= '0;
                    r_inst[r*2 +: 2]  <= 2'b00;
                end
            end
            r_full  <= ((w_wp_nx - w_rpl_nx) == PW'(depth));
            r_done  <= (r_state != ST_IDLE) && (r_tick == w_done_t);
            r_err   <= w_reject;
        end
    end

    assign o_full   = r_full;
    assign o_out    = r_out;
    assign o_inst_w = r_inst;
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

// File: tb/tb_l0_skew_feeder.sv
// tb/tb_l0_skew_feeder.sv - Directed self-checking bench for l0_skew_feeder (skew mode follows FEEDER_SKEW_EN).
module tb_l0_skew_feeder;
    localparam int ROW = 8;
    localparam int BW  = 4;
    localparam int DEPTH = 64;
`ifdef FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr;
    logic [ROW*BW-1:0] din;
    logic              full;
    logic              start_load;
    logic              start_exec;
    logic [6:0]        len;
    logic [ROW*BW-1:0] dout;
    logic [ROW*2-1:0]  inst;
    logic              busy;
    logic              done;
    logic              err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int pat_idx = 0;
    logic [31:0] mq [$];

    l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_in(din), .o_full(full),
        .i_start_load(start_load), .i_start_exec(start_exec), .i_len(len),
        .o_out(dout), .o_inst_w(inst), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int n);
        logic [31:0] v;
        v = 32'(n + 1) * 32'h9E37_79B9;
        return v ^ 32'(n);
    endfunction

    task automatic push_one();
        wr  = 1'b1;
        din = pat(pat_idx);
        mq.push_back(din);
        pat_idx++;
        tick();
        wr = 1'b0;
    endtask

    task automatic expect_err(input logic ld, input logic ex, input int n, input string tag);
        start_load = ld;
        start_exec = ex;
        len        = 7'(n);
        tick();
        start_load = 1'b0;
        start_exec = 1'b0;
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out"}, dout, 32'd0);
        chk({tag, "_inst"}, 32'(inst), 32'd0);
        tick();
        chk({tag, "_err_clr"}, 32'(err), 32'd0);
    endtask

    // Model of one pass: lane r shows vector k in cycle S+1+k+off(r).
    task automatic run_pass(input logic [1:0] code, input int n, input int npush, input string tag);
        logic [31:0] ev [$];
        logic [31:0] e_out;
        logic [15:0] e_inst;
        int last, off, k, occ_start, pushed, issued, slow_off;
        ev        = mq;
        occ_start = mq.size();
        last      = n + (SKEW ? ROW : 1);
        slow_off  = SKEW ? ROW - 1 : 0;
        start_load = (code == 2'b01);
        start_exec = (code == 2'b10);
        len        = 7'(n);
        tick();
        start_load = 1'b0;
        start_exec = 1'b0;
        for (int j = 1; j <= last + 1; j++) begin
            e_out  = '0;
            e_inst = '0;
            for (int r = 0; r < ROW; r++) begin
                off = SKEW ? r : 0;
                k   = j - 1 - off;
                if (k >= 0 && k < n) begin
                    e_out[r*BW +: BW] = ev[k][r*BW +: BW];
                    e_inst[r*2 +: 2]  = code;
                end
            end
            pushed = (j - 1 < npush) ? j - 1 : npush;
            issued = j - slow_off;
            if (issued < 0) issued = 0;
            if (issued > n) issued = n;
            chk($sformatf("%s_out_c%0d", tag, j), dout, e_out);
            chk($sformatf("%s_inst_c%0d", tag, j), 32'(inst), 32'(e_inst));
            chk($sformatf("%s_busy_c%0d", tag, j), 32'(busy), 32'(j <= last));
            chk($sformatf("%s_done_c%0d", tag, j), 32'(done), 32'(j == last));
            chk($sformatf("%s_full_c%0d", tag, j), 32'(full), 32'((occ_start + pushed - issued) == DEPTH));
            chk($sformatf("%s_err_c%0d", tag, j), 32'(err), 32'd0);
            if (j <= npush) begin
                wr  = 1'b1;
                din = pat(pat_idx);
                mq.push_back(din);
                pat_idx++;
            end else begin
                wr = 1'b0;
            end
            tick();
        end
        wr = 1'b0;
        for (int i = 0; i < n; i++) mq.delete(0);
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; din = '0; start_load = 1'b0; start_exec = 1'b0; len = '0;
        tick();
        tick();
        chk("rst_out", dout, 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of an execute pass.
        for (int i = 0; i < 4; i++) push_one();
        start_exec = 1'b1;
        len = 7'd4;
        tick();
        start_exec = 1'b0;
        tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", dout, 32'd0);
        chk("mid_rst_inst", 32'(inst), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        mq.delete();
        tick();
        chk("post_rst_full", 32'(full), 32'd0);
        expect_err(1'b0, 1'b1, 1, "post_rst_empty");

        // Kernel-load pass of 4 vectors.
        for (int i = 0; i < 4; i++) push_one();
        run_pass(2'b01, 4, 0, "load4");

        // Fill to capacity, drop the overflow push, then drain with one full pass.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("fill_full_pre", 32'(full), 32'd0);
            push_one();
        end
        chk("fill_full", 32'(full), 32'd1);
        wr  = 1'b1;
        din = 32'hDEAD_BEEF;
        tick();
        wr = 1'b0;
        chk("drop_full", 32'(full), 32'd1);
        run_pass(2'b10, DEPTH, 0, "exec64");
        chk("after64_full", 32'(full), 32'd0);
        expect_err(1'b0, 1'b1, 1, "drop_empty");

        // Rejected starts leave the FSM idle.
        for (int i = 0; i < 3; i++) push_one();
        expect_err(1'b0, 1'b1, 5, "short_occ");
        expect_err(1'b1, 1'b1, 1, "both_starts");
        expect_err(1'b0, 1'b1, 0, "len_zero");
        run_pass(2'b10, 3, 0, "exec3");

        // Pushes during a pass are served by the following pass.
        for (int i = 0; i < 4; i++) push_one();
        run_pass(2'b10, 4, 4, "exec_a");
        run_pass(2'b10, 4, 0, "exec_b");
        expect_err(1'b1, 1'b0, 1, "final_empty");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
